// File: rtl/wb_rom_pkg.sv
// Shared types for the Wishbone ROM arbiter: FSM states and port select.
package wb_rom_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StAck
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant when enabled, ties go to the port not granted last.
module rr_arbiter2
  import wb_rom_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  port_e last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_q == PORT_D) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    if (gnt_o[0]) begin
      last_d = PORT_I;
    end else if (gnt_o[1]) begin
      last_d = PORT_D;
    end
  end

  // Reset to the data port so the instruction port wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= PORT_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/wb_rom_arbiter.sv
// Shares one external synchronous ROM between Wishbone classic instruction and data ports.
module wb_rom_arbiter
  import wb_rom_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [15:0] CONT_MAX   = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cyc_i,
  input  logic                  i_stb_i,
  input  logic                  i_we_i,
  input  logic [ADDR_WIDTH-1:0] i_adr_i,
  output logic [DATA_WIDTH-1:0] i_dat_o,
  output logic                  i_ack_o,
  output logic                  i_err_o,
  input  logic                  d_cyc_i,
  input  logic                  d_stb_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_adr_i,
  output logic [DATA_WIDTH-1:0] d_dat_o,
  output logic                  d_ack_o,
  output logic                  d_err_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_q_i,
  output logic [15:0]           contention_o
);

  state_e                state_q, state_d;
  port_e                 port_q, port_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] i_dat_q, i_dat_d, d_dat_q, d_dat_d;
  logic [15:0]           cont_q, cont_d;
  logic [1:0]            req, gnt;
  logic                  sel_cyc;

  assign req     = {d_cyc_i & d_stb_i, i_cyc_i & i_stb_i};
  assign sel_cyc = (port_q == PORT_I) ? i_cyc_i : d_cyc_i;

  rr_arbiter2 u_arb (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (req),
    .en_i  (state_q == StIdle),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    i_dat_d = i_dat_q;
    d_dat_d = d_dat_q;
    cont_d  = cont_q;
    unique case (state_q)
      StIdle: begin
        if (req == 2'b11 && cont_q != CONT_MAX) begin
          cont_d = cont_q + 16'd1;
        end
        if (gnt != 2'b00) begin
          port_d = gnt[1] ? PORT_D : PORT_I;
          we_d   = gnt[1] ? d_we_i : i_we_i;
          // Writes are refused, so they never disturb the ROM address.
          if (!we_d) begin
            addr_d  = gnt[1] ? d_adr_i : i_adr_i;
            state_d = StAddr;
          end else begin
            state_d = StAck;
          end
        end
      end
      StAddr: begin
        state_d = sel_cyc ? StData : StIdle;
      end
      StData: begin
        if (!sel_cyc) begin
          state_d = StIdle;
        end else begin
          if (port_q == PORT_I) begin
            i_dat_d = rom_q_i;
          end else begin
            d_dat_d = rom_q_i;
          end
          state_d = StAck;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      port_q  <= PORT_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      i_dat_q <= '0;
      d_dat_q <= '0;
      cont_q  <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      i_dat_q <= i_dat_d;
      d_dat_q <= d_dat_d;
      cont_q  <= cont_d;
    end
  end

  always_comb begin
    i_ack_o = (state_q == StAck) && (port_q == PORT_I) && !we_q;
    i_err_o = (state_q == StAck) && (port_q == PORT_I) && we_q;
    d_ack_o = (state_q == StAck) && (port_q == PORT_D) && !we_q;
    d_err_o = (state_q == StAck) && (port_q == PORT_D) && we_q;
  end

  assign i_dat_o      = i_dat_q;
  assign d_dat_o      = d_dat_q;
  assign rom_addr_o   = addr_q;
  assign contention_o = cont_q;

endmodule
